// File: rtl/pic_inta_sequencer_if.sv
// Bus between the 8259 priority/control logic, the CPU INTA handshake and the sequencer.
interface pic_inta_sequencer_if #(
    parameter int unsigned ISR_W = 8
);
    localparam int unsigned LVL_W = $clog2(ISR_W);

    logic [ISR_W-1:0] interrupt_vector;
    logic [LVL_W-1:0] priority_rotate;
    logic [4:0]       icw2_base;
    logic             auto_eoi;
    logic             inta_n;
    logic             eoi_valid;
    logic             eoi_specific;
    logic [LVL_W-1:0] eoi_level;
    logic             int_out;
    logic [ISR_W-1:0] isr;
    logic [ISR_W-1:0] clear_irr;
    logic [7:0]       data_out;
    logic             data_oe;

    modport master (
        output interrupt_vector, priority_rotate, icw2_base, auto_eoi, inta_n,
               eoi_valid, eoi_specific, eoi_level,
        input  int_out, isr, clear_irr, data_out, data_oe
    );

    modport slave (
        input  interrupt_vector, priority_rotate, icw2_base, auto_eoi, inta_n,
               eoi_valid, eoi_specific, eoi_level,
        output int_out, isr, clear_irr, data_out, data_oe
    );
endinterface

// File: rtl/pic_inta_sequencer.sv
// 8259 interrupt-acknowledge sequencer: raises INT, runs the two-pulse 8086 INTA
// handshake, maintains the in-service register and retires it on EOI / auto-EOI.
module pic_inta_sequencer #(
    parameter int unsigned ISR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pic_inta_sequencer_if.slave  bus
);
    localparam int unsigned LVL_W = $clog2(ISR_W);

    typedef enum logic [2:0] {IDLE, REQ, ACK1, WAIT2, ACK2} state_t;

    state_t           state;
    logic             inta_q;
    logic [LVL_W-1:0] level;
    logic             spurious;
    logic             int_q;
    logic [ISR_W-1:0] isr_q;
    logic [ISR_W-1:0] clear_q;
    logic [7:0]       dout_q;
    logic             oe_q;

    logic             fall_c;
    logic             rise_c;
    logic [LVL_W-1:0] enc_c;
    logic [ISR_W-1:0] set_c;
    logic [ISR_W-1:0] aeoi_c;
    logic [ISR_W-1:0] eoi_c;
    logic [LVL_W-1:0] idx_c;
    logic             found_c;

    assign fall_c = inta_q & ~bus.inta_n;
    assign rise_c = ~inta_q & bus.inta_n;

    // Index of the resolver's request bit (the vector is one-hot).
    always_comb begin
        enc_c = '0;
        for (int i = ISR_W - 1; i >= 0; i--) begin
            if (bus.interrupt_vector[i]) enc_c = LVL_W'(i);
        end
    end

    // ISR set at the first fall and auto-EOI clear at the second rise.
    always_comb begin
        set_c  = '0;
        aeoi_c = '0;
        if (state == REQ && fall_c && (|bus.interrupt_vector)) set_c[enc_c] = 1'b1;
        if (state == ACK2 && rise_c && bus.auto_eoi && !spurious) aeoi_c[level] = 1'b1;
    end

    // EOI clear mask; the non-specific scan starts just above the lowest-priority level.
    always_comb begin
        eoi_c   = '0;
        idx_c   = '0;
        found_c = 1'b0;
        if (bus.eoi_valid) begin
            if (bus.eoi_specific) begin
                eoi_c[bus.eoi_level] = 1'b1;
            end else begin
                for (int i = 0; i < ISR_W; i++) begin
                    idx_c = LVL_W'(bus.priority_rotate + LVL_W'(1) + LVL_W'(i));
                    if (!found_c && isr_q[idx_c]) begin
                        eoi_c[idx_c] = 1'b1;
                        found_c      = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            inta_q   <= 1'b1;
            level    <= '0;
            spurious <= 1'b0;
            int_q    <= 1'b0;
            isr_q    <= '0;
            clear_q  <= '0;
            dout_q   <= 8'h00;
            oe_q     <= 1'b0;
        end else begin
            inta_q  <= bus.inta_n;
            clear_q <= '0;
            isr_q   <= (isr_q & ~eoi_c & ~aeoi_c) | set_c;
            case (state)
                IDLE: begin
                    if (|bus.interrupt_vector) begin
                        int_q <= 1'b1;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (fall_c) begin
                        int_q <= 1'b0;
                        state <= ACK1;
                        if (|bus.interrupt_vector) begin
                            level    <= enc_c;
                            spurious <= 1'b0;
                            clear_q  <= set_c;
                        end else begin
                            level    <= LVL_W'(ISR_W - 1);
                            spurious <= 1'b1;
                        end
                    end
                end
                ACK1: begin
                    if (rise_c) state <= WAIT2;
                end
                WAIT2: begin
                    if (fall_c) begin
                        oe_q   <= 1'b1;
                        dout_q <= {bus.icw2_base, level};
                        state  <= ACK2;
                    end
                end
                ACK2: begin
                    if (rise_c) begin
                        oe_q   <= 1'b0;
                        dout_q <= 8'h00;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.int_out   = int_q;
    assign bus.isr       = isr_q;
    assign bus.clear_irr = clear_q;
    assign bus.data_out  = dout_q;
    assign bus.data_oe   = oe_q;
endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed self-checking bench for pic_inta_sequencer with hand-computed expectations.
module tb_pic_inta_sequencer;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    pic_inta_sequencer_if #(.ISR_W(8)) bus ();

    pic_inta_sequencer #(.ISR_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full two-pulse acknowledge; spur withdraws the vector before the first fall.
    task automatic run_ack(input logic [7:0] vec, input bit spur,
                           output logic int1, output logic [7:0] isr1, output logic [7:0] clr1,
                           output logic [7:0] clr2, output logic [7:0] dout2, output logic oe2,
                           output logic [7:0] isr_end, output logic oe_end, output logic [7:0] dout_end);
        bus.interrupt_vector = vec;
        tick();
        int1 = bus.int_out;
        if (spur) bus.interrupt_vector = 8'h00;
        bus.inta_n = 1'b0;
        tick();
        isr1 = bus.isr;
        clr1 = bus.clear_irr;
        bus.inta_n = 1'b1;
        bus.interrupt_vector = 8'h00;
        tick();
        clr2 = bus.clear_irr;
        bus.inta_n = 1'b0;
        tick();
        dout2 = bus.data_out;
        oe2   = bus.data_oe;
        bus.inta_n = 1'b1;
        tick();
        isr_end  = bus.isr;
        oe_end   = bus.data_oe;
        dout_end = bus.data_out;
    endtask

    task automatic send_eoi(input bit specific, input logic [2:0] lvl);
        bus.eoi_valid    = 1'b1;
        bus.eoi_specific = specific;
        bus.eoi_level    = lvl;
        tick();
        bus.eoi_valid    = 1'b0;
    endtask

    initial begin
        logic       int1, oe2, oe_end, oe_seen;
        logic [7:0] isr1, clr1, clr2, dout2, isr_end, dout_end;
        n_cmp = 0;
        n_err = 0;

        // Reset with random inputs
        reset_n              = 1'b0;
        bus.interrupt_vector = 8'($urandom);
        bus.priority_rotate  = 3'($urandom);
        bus.icw2_base        = 5'($urandom);
        bus.auto_eoi         = 1'($urandom);
        bus.inta_n           = 1'($urandom);
        bus.eoi_valid        = 1'($urandom);
        bus.eoi_specific     = 1'($urandom);
        bus.eoi_level        = 3'($urandom);
        tick();
        tick();
        check("rst_int", 32'(bus.int_out), 32'd0);
        check("rst_isr", 32'(bus.isr), 32'h00);
        check("rst_clr", 32'(bus.clear_irr), 32'h00);
        check("rst_oe", 32'(bus.data_oe), 32'd0);
        check("rst_dout", 32'(bus.data_out), 32'h00);

        bus.interrupt_vector = 8'h00;
        bus.priority_rotate  = 3'd7;
        bus.icw2_base        = 5'h01;
        bus.auto_eoi         = 1'b0;
        bus.inta_n           = 1'b1;
        bus.eoi_valid        = 1'b0;
        bus.eoi_specific     = 1'b0;
        bus.eoi_level        = 3'd0;
        tick();
        reset_n = 1'b1;
        tick();
        check("idle_int", 32'(bus.int_out), 32'd0);

        // Normal acknowledge, level 3
        run_ack(8'h08, 1'b0, int1, isr1, clr1, clr2, dout2, oe2, isr_end, oe_end, dout_end);
        check("norm_int", 32'(int1), 32'd1);
        check("norm_isr1", 32'(isr1), 32'h08);
        check("norm_clr1", 32'(clr1), 32'h08);
        check("norm_clr2", 32'(clr2), 32'h00);
        check("norm_dout", 32'(dout2), 32'h0B);
        check("norm_oe", 32'(oe2), 32'd1);
        check("norm_isr_end", 32'(isr_end), 32'h08);
        check("norm_oe_end", 32'(oe_end), 32'd0);
        check("norm_dout_end", 32'(dout_end), 32'h00);
        check("norm_int_idle", 32'(bus.int_out), 32'd0);

        send_eoi(1'b1, 3'd3);
        check("seoi3", 32'(bus.isr), 32'h00);

        // Auto-EOI
        bus.auto_eoi = 1'b1;
        run_ack(8'h08, 1'b0, int1, isr1, clr1, clr2, dout2, oe2, isr_end, oe_end, dout_end);
        check("aeoi_isr1", 32'(isr1), 32'h08);
        check("aeoi_dout", 32'(dout2), 32'h0B);
        check("aeoi_isr_end", 32'(isr_end), 32'h00);
        bus.auto_eoi = 1'b0;

        // Build isr = 0x21, then rotated non-specific EOIs
        run_ack(8'h01, 1'b0, int1, isr1, clr1, clr2, dout2, oe2, isr_end, oe_end, dout_end);
        check("l0_dout", 32'(dout2), 32'h08);
        run_ack(8'h20, 1'b0, int1, isr1, clr1, clr2, dout2, oe2, isr_end, oe_end, dout_end);
        check("l5_clr1", 32'(clr1), 32'h20);
        check("l5_isr_end", 32'(isr_end), 32'h21);
        bus.priority_rotate = 3'd2;
        send_eoi(1'b0, 3'd0);
        check("nseoi1", 32'(bus.isr), 32'h01);
        send_eoi(1'b0, 3'd0);
        check("nseoi2", 32'(bus.isr), 32'h00);
        send_eoi(1'b0, 3'd0);
        check("nseoi_empty", 32'(bus.isr), 32'h00);

        // Spurious request with isr = 0x21
        run_ack(8'h01, 1'b0, int1, isr1, clr1, clr2, dout2, oe2, isr_end, oe_end, dout_end);
        run_ack(8'h20, 1'b0, int1, isr1, clr1, clr2, dout2, oe2, isr_end, oe_end, dout_end);
        run_ack(8'h10, 1'b1, int1, isr1, clr1, clr2, dout2, oe2, isr_end, oe_end, dout_end);
        check("spur_int", 32'(int1), 32'd1);
        check("spur_isr1", 32'(isr1), 32'h21);
        check("spur_clr1", 32'(clr1), 32'h00);
        check("spur_clr2", 32'(clr2), 32'h00);
        check("spur_dout", 32'(dout2), 32'h0F);
        check("spur_oe", 32'(oe2), 32'd1);
        check("spur_isr_end", 32'(isr_end), 32'h21);

        send_eoi(1'b1, 3'd5);
        check("seoi5", 32'(bus.isr), 32'h01);
        send_eoi(1'b1, 3'd5);
        check("seoi5_again", 32'(bus.isr), 32'h01);

        // Reset during WAIT2
        bus.interrupt_vector = 8'h04;
        tick();
        bus.inta_n = 1'b0;
        tick();
        check("mid_isr", 32'(bus.isr), 32'h05);
        bus.inta_n = 1'b1;
        bus.interrupt_vector = 8'h00;
        tick();
        reset_n = 1'b0;
        #1;
        check("mid_rst_isr", 32'(bus.isr), 32'h00);
        check("mid_rst_oe", 32'(bus.data_oe), 32'd0);
        tick();
        reset_n = 1'b1;
        oe_seen = 1'b0;
        for (int p = 0; p < 2; p++) begin
            bus.inta_n = 1'b0;
            tick();
            oe_seen |= bus.data_oe;
            bus.inta_n = 1'b1;
            tick();
            oe_seen |= bus.data_oe;
        end
        check("post_rst_oe", 32'(oe_seen), 32'd0);
        check("post_rst_int", 32'(bus.int_out), 32'd0);
        bus.interrupt_vector = 8'h02;
        tick();
        check("post_rst_int_req", 32'(bus.int_out), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
